fifo_n: RTL

Parametrised N-entry synchronous FIFO, the multi-entry successor to the single-register enq/deq buffer used in the ft600 datapath. It sits between USB-FIFO bridge stages and the request/indication pipes and decouples producer and consumer by up to DEPTH transfers. It adds occupancy and almost-full reporting, and optionally supports enqueue-while-full when a dequeue happens in the same cycle. It uses the same ENA/RDY method handshake as the rest of the ft600 design.

---
 rtl/fifo_n.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_n.sv
// fifo_n: parametrised DEPTH-entry synchronous FIFO with ENA/RDY method handshake.
// Optional macro FIFO_N_PIPELINE_EN allows enqueue into a full FIFO when a dequeue fires in the same cycle.
module fifo_n #(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  output logic                   in_afull,
  input  logic                   out_deq__ENA,
  output logic                   out_deq__RDY,
  output logic [WIDTH-1:0]       out_first,
  output logic                   out_first__RDY,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             empty;
  logic             full;
  logic             enq_fire;
  logic             deq_fire;

  // Status flags derived purely from the occupancy register
  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));

`ifdef FIFO_N_PIPELINE_EN
  // A same-cycle dequeue frees the slot the enqueue will use
  assign in_enq__RDY = !full | out_deq__ENA;
`else
  assign in_enq__RDY = !full;
`endif

  assign out_deq__RDY   = !empty;
  assign out_first__RDY = !empty;
  assign out_first      = mem[rp];
  assign in_afull       = (count_q >= CW'(AFULL_LEVEL));
  assign count          = count_q;

  assign enq_fire = in_enq__ENA & in_enq__RDY;
  assign deq_fire = out_deq__ENA & out_deq__RDY;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (enq_fire) begin
        mem[wp] <= in_enq_v;
        wp      <= wp + AW'(1);
      end
      if (deq_fire) begin
        rp <= rp + AW'(1);
      end
    end
  end

endmodule
